// File: rtl/mm_exp_step.sv
// One step of right-to-left binary modular exponentiation: square the base, conditionally multiply the accumulator, shift the exponent.
// Optional build macro MM_KEY_ZERO_HOLD_EN freezes the base once the exponent reaches zero.
module mm_exp_step #(
    parameter int KEY_W  = 2048,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  in_temp_key,
    input  logic [DATA_W-1:0] in_text,
    input  logic [DATA_W-1:0] in_answer,
    input  logic [KEY_W-1:0]  in_N,
    output logic [KEY_W-1:0]  MM_temp_key,
    output logic [DATA_W-1:0] MM_text,
    output logic [DATA_W-1:0] MM_answer
);

    localparam int PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] n;
    logic              key_zero;
    logic              hold;
    logic [DATA_W-1:0] text_op;
    logic [PROD_W-1:0] prod [2];
    logic [DATA_W-1:0] red [2];
    logic [KEY_W-1:0]  key_next;
    logic [DATA_W-1:0] text_next;
    logic [DATA_W-1:0] answer_next;
    logic              unused_n_upper;

    assign n              = in_N[DATA_W-1:0];
    assign unused_n_upper = |in_N[KEY_W-1:DATA_W];
    assign key_zero       = (in_temp_key == '0);

`ifdef MM_KEY_ZERO_HOLD_EN
    assign hold = key_zero;
`else
    assign hold = 1'b0;
`endif

    // Gating the operand keeps the multipliers quiet while the base is frozen.
    assign text_op = hold ? '0 : in_text;
    assign prod[0] = {{DATA_W{1'b0}}, text_op} * {{DATA_W{1'b0}}, text_op};
    assign prod[1] = {{DATA_W{1'b0}}, in_answer} * {{DATA_W{1'b0}}, text_op};

    // Restoring reduction, MSB first; the partial remainder stays below 2n so DATA_W+1 bits suffice.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reduce
            always_comb begin
                logic [DATA_W:0] rem;
                rem = '0;
                for (int b = PROD_W - 1; b >= 0; b--) begin
                    rem = {rem[DATA_W-1:0], prod[gi][b]};
                    if (rem >= {1'b0, n}) begin
                        rem = rem - {1'b0, n};
                    end
                end
                red[gi] = (n == '0) ? prod[gi][DATA_W-1:0] : rem[DATA_W-1:0];
            end
        end
    endgenerate

    always_comb begin
        key_next    = in_temp_key >> 1;
        text_next   = hold ? in_text : red[0];
        answer_next = (in_temp_key[0] && !hold) ? red[1] : in_answer;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            MM_temp_key <= '0;
            MM_text     <= '0;
            MM_answer   <= '0;
        end else begin
            MM_temp_key <= key_next;
            MM_text     <= text_next;
            MM_answer   <= answer_next;
        end
    end

endmodule

// File: tb/tb_mm_exp_step.sv
// Directed vector bench for mm_exp_step: table of single steps plus feedback and reset sequences.
module tb_mm_exp_step;

    localparam int KEY_W  = 2048;
    localparam int DATA_W = 32;

    typedef struct {
        string             name;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] text;
        logic [DATA_W-1:0] answer;
        logic [KEY_W-1:0]  n;
        logic [KEY_W-1:0]  exp_key;
        logic [DATA_W-1:0] exp_text;
        logic [DATA_W-1:0] exp_answer;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [KEY_W-1:0]  in_temp_key;
    logic [DATA_W-1:0] in_text;
    logic [DATA_W-1:0] in_answer;
    logic [KEY_W-1:0]  in_N;
    logic [KEY_W-1:0]  MM_temp_key;
    logic [DATA_W-1:0] MM_text;
    logic [DATA_W-1:0] MM_answer;

    int   n_compared = 0;
    int   n_mismatch = 0;
    vec_t vecs [16];
    int   n_vecs = 0;

    mm_exp_step #(.KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_temp_key (in_temp_key),
        .in_text     (in_text),
        .in_answer   (in_answer),
        .in_N        (in_N),
        .MM_temp_key (MM_temp_key),
        .MM_text     (MM_text),
        .MM_answer   (MM_answer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input string name, input logic [KEY_W-1:0] key,
                           input logic [DATA_W-1:0] text, input logic [DATA_W-1:0] answer,
                           input logic [KEY_W-1:0] n, input logic [KEY_W-1:0] exp_key,
                           input logic [DATA_W-1:0] exp_text, input logic [DATA_W-1:0] exp_answer);
        vecs[n_vecs] = '{name, key, text, answer, n, exp_key, exp_text, exp_answer};
        n_vecs++;
    endtask

    // Compares all three outputs; key printed as its low 128 bits plus MSB to keep lines short.
    task automatic check(input string name, input logic [KEY_W-1:0] exp_key,
                         input logic [DATA_W-1:0] exp_text, input logic [DATA_W-1:0] exp_answer);
        n_compared += 3;
        if (MM_temp_key !== exp_key) begin
            n_mismatch++;
            $display("FAIL %s key: got msb=%0b lo=%0h expected msb=%0b lo=%0h", name,
                     MM_temp_key[KEY_W-1], MM_temp_key[127:0], exp_key[KEY_W-1], exp_key[127:0]);
        end
        if (MM_text !== exp_text) begin
            n_mismatch++;
            $display("FAIL %s text: got %0d expected %0d", name, MM_text, exp_text);
        end
        if (MM_answer !== exp_answer) begin
            n_mismatch++;
            $display("FAIL %s answer: got %0d expected %0d", name, MM_answer, exp_answer);
        end
        $display("step %s: key=%0h text=%0d answer=%0d", name, MM_temp_key[127:0], MM_text, MM_answer);
    endtask

    task automatic drive(input logic rst, input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] text,
                         input logic [DATA_W-1:0] answer, input logic [KEY_W-1:0] n);
        rst_n       = rst;
        in_temp_key = key;
        in_text     = text;
        in_answer   = answer;
        in_N        = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [KEY_W-1:0]  one;
        logic [KEY_W-1:0]  n_hi;
        logic [KEY_W-1:0]  k;
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] zk_text;

        one  = 1;
        n_hi = (one << (KEY_W - 1)) | 23;
`ifdef MM_KEY_ZERO_HOLD_EN
        zk_text = 5;
`else
        zk_text = 2;
`endif

        add_vec("s1",        13, 5,  1,  23, 6, 2,  5);
        add_vec("s2",        6,  2,  5,  23, 3, 4,  5);
        add_vec("s3",        3,  4,  5,  23, 1, 16, 20);
        add_vec("s4",        1,  16, 20, 23, 0, 3,  21);
        add_vec("max",       1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 16, 16);
        add_vec("n1_bit1",   1,  7,  9,  1,  0, 0,  0);
        add_vec("n1_bit0",   2,  7,  9,  1,  1, 0,  9);
        add_vec("n0",        1,  3,  7,  0,  0, 9,  21);
        add_vec("n_upper",   13, 5,  1,  n_hi, 6, 2, 5);
        add_vec("big_ops",   1,  100, 50, 7, 0, 4,  2);
        add_vec("key_msb",   (one << (KEY_W - 1)) | 5, 5, 1, 23, (one << (KEY_W - 2)) | 2, 2, 5);
        add_vec("key_zero",  0,  5,  21, 23, 0, zk_text, 21);

        drive(1'b1, 13, 5, 1, 23);
        check("reset", 0, 0, 0);

        for (int i = 0; i < n_vecs; i++) begin
            drive(1'b0, vecs[i].key, vecs[i].text, vecs[i].answer, vecs[i].n);
            check(vecs[i].name, vecs[i].exp_key, vecs[i].exp_text, vecs[i].exp_answer);
        end

        // Full 5^13 mod 23 with outputs fed back.
        drive(1'b0, 13, 5, 1, 23);
        check("fb1", 6, 2, 5);
        for (int s = 2; s <= 4; s++) begin
            k = MM_temp_key; t = MM_text; a = MM_answer;
            drive(1'b0, k, t, a, 23);
            case (s)
                2:       check("fb2", 3, 4, 5);
                3:       check("fb3", 1, 16, 20);
                default: check("fb4", 0, 3, 21);
            endcase
        end

        // Reset asserted during step 3 wipes state, then the run restarts cleanly.
        drive(1'b0, 13, 5, 1, 23);
        k = MM_temp_key; t = MM_text; a = MM_answer;
        drive(1'b0, k, t, a, 23);
        k = MM_temp_key; t = MM_text; a = MM_answer;
        drive(1'b1, k, t, a, 23);
        check("rst_mid", 0, 0, 0);
        drive(1'b0, 13, 5, 1, 23);
        check("restart", 6, 2, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/mm_exp_step.md
Name: mm_exp_step

Overview:
- One-step modular-exponentiation datapath for the RSA engine. The exponentiation controller drives it, and its outputs feed back to its inputs.
- Each clock it consumes one exponent bit (LSB-first, right-to-left binary method):
  - conditionally multiplies the accumulator by the base modulo N;
  - squares the base modulo N;
  - shifts the exponent right by one bit.
- All outputs are registered. Latency is 1 cycle, and throughput is one step per cycle.

Parameters:
- KEY_W, 2048, width of the exponent shift register and of the modulus input bus.
- DATA_W, 32, width of the base/accumulator operands and of the effective modulus.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset. The name is kept for codebase consistency; the port is active-high.
- in_temp_key  input  KEY_W  current remaining exponent.
- in_text  input  DATA_W  current base (repeatedly squared).
- in_answer  input  DATA_W  current accumulator.
- in_N  input  KEY_W  modulus; only bits [DATA_W-1:0] are used, upper bits are ignored.
- MM_temp_key  output  KEY_W  next exponent (registered).
- MM_text  output  DATA_W  next base (registered).
- MM_answer  output  DATA_W  next accumulator (registered).

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-high.
- Reset: on a rising edge with rst_n=1, MM_temp_key, MM_text and MM_answer all become 0. Reset overrides any step in progress, including mid-exponentiation; no partial result survives.
- Definitions: n = in_N[DATA_W-1:0]; full products are 2*DATA_W bits wide, with no truncation before reduction.
- Normal cycle (rst_n=0), all updated on the same edge:
  - MM_temp_key <= in_temp_key >> 1 (logical shift, zero fill at MSB).
  - MM_text <= (in_text * in_text) mod n.
  - MM_answer <= in_temp_key[0] ? (in_answer * in_text) mod n : in_answer.
  - The multiply uses the pre-update in_text, not the squared value.
- Reduction is a true full modulo, so operands >= n are still reduced correctly.
- Boundary n == 1: both modular results are 0, including MM_answer when in_temp_key[0]=1. MM_answer passes through unchanged when the bit is 0.
- Boundary n == 0: no reduction. The result is the low DATA_W bits of the product.
- in_temp_key == 0: the key stays 0, and the answer is held. The text is still squared unless the optional feature is enabled.
- Outputs are combinationally independent of the outputs themselves; a feedback loop through the controller is legal.
- Reduction must complete within one cycle. The implementation is free to choose its structure (restoring division, Barrett, etc.), provided results match the equations above bit-exactly.
- No handshake: inputs are sampled every cycle and the controller decides when to stop. It stops when MM_temp_key == 0.

Optional Feature:
- Macro: MM_KEY_ZERO_HOLD_EN.
- When defined: if in_temp_key == 0, MM_text <= in_text (squaring suppressed, multiplier operands gated) and MM_answer holds. This saves power once exponentiation completes.
- When undefined: squaring proceeds every cycle regardless of key value, per the normal equations.
- Reset behaviour is identical with and without the macro.

Test Plan:
- Full exponentiation 5^13 mod 23: in_text=5, in_answer=1, in_temp_key=13, in_N=23, with outputs fed back each cycle.
  - Step 1: (key,text,answer) = (6,2,5).
  - Step 2: (3,4,5).
  - Step 3: (1,16,20).
  - Step 4: (0,3,21). Final answer is 21.
- Max operands: in_text=in_answer=0xFFFFFFFF, in_temp_key=1, in_N=0xFFFFFFFB -> MM_answer=16, MM_text=16, MM_temp_key=0.
- Modulus boundaries:
  - n=1, text=7, answer=9, key=1 -> answer=0, text=0.
  - n=0, text=3, answer=7, key=1 -> answer=21, text=9.
- Upper modulus bits ignored: in_N with bit 2047 set and low word 23, text=5, answer=1, key=13 -> identical to the first scenario's step 1, (6,2,5).
- Reset mid-run:
  - Assert rst_n=1 during step 3 of the first scenario -> all outputs 0 on that edge.
  - After release and re-driving the step-1 inputs -> sequence restarts from (6,2,5).
- Key zero, text=5, answer=21, n=23:
  - With MM_KEY_ZERO_HOLD_EN -> (0,5,21).
  - Without it -> (0,2,21).
